// File: rtl/multi_channel_join_stage_if.sv
// Handshake bundle for the multi-channel join stage: NCH joined input channels,
// one buffered output channel and the completed-transfer counter.
interface multi_channel_join_stage_if #(
   parameter int NCH   = 2,
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
);
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic [NCH*WIDTH-1:0] in_data;
   logic [1:0]           mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;
   logic [CNTW-1:0]      xfer_count;

   modport slave (
      input  in_valid, in_data, mode, out_ready,
      output in_ready, out_valid, out_data, xfer_count
   );

   modport master (
      output in_valid, in_data, mode, out_ready,
      input  in_ready, out_valid, out_data, xfer_count
   );
endinterface

// File: rtl/multi_channel_join_stage.sv
// Joins NCH ready/valid channels in lockstep, reduces their data bitwise and
// queues the result in a DEPTH-entry FIFO that drives one ready/valid consumer.
module multi_channel_join_stage #(
   parameter int NCH   = 2,
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNTW  = 16
) (
   input logic                  C0,
   input logic                  reset,
   multi_channel_join_stage_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0]   PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [PW-1:0]   PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] XFER_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CNTW-1:0]  r_xfer;

   logic             w_space;
   logic             w_all_valid;
   logic             w_push;
   logic             w_pop;
   logic             w_out_valid;
   logic [NCH-1:0]   w_in_ready;
   logic [WIDTH-1:0] w_result_p0;

   function automatic logic [WIDTH-1:0] f_reduce(input logic [NCH*WIDTH-1:0] data,
                                                 input logic [1:0]           sel);
      logic [WIDTH-1:0] v_and;
      logic [WIDTH-1:0] v_or;
      logic [WIDTH-1:0] v_xor;
      v_and = '1;
      v_or  = '0;
      v_xor = '0;
      for (int i = 0; i < NCH; i++) begin
         v_and = v_and & data[i*WIDTH +: WIDTH];
         v_or  = v_or  | data[i*WIDTH +: WIDTH];
         v_xor = v_xor ^ data[i*WIDTH +: WIDTH];
      end
      case (sel)
         2'd0:    f_reduce = v_and;
         2'd1:    f_reduce = v_or;
         2'd2:    f_reduce = v_xor;
         default: f_reduce = data[WIDTH-1:0];
      endcase
   endfunction

   function automatic logic [PW-1:0] f_ptr_next(input logic [PW-1:0] p);
      f_ptr_next = (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // Space comes from registered occupancy only, so out_ready never reaches in_ready.
   assign w_space     = (r_count < CNT_FULL);
   assign w_all_valid = &bus.in_valid;
   assign w_push      = w_all_valid & w_space;
   assign w_out_valid = (r_count != '0);
   assign w_pop       = w_out_valid & bus.out_ready;
   assign w_result_p0 = f_reduce(bus.in_data, bus.mode);

   // A channel's ready looks only at its peers, so all channels accept together.
   always_comb begin
      w_in_ready = '0;
      for (int i = 0; i < NCH; i++) begin
         w_in_ready[i] = w_space;
         for (int j = 0; j < NCH; j++) begin
            if (j != i) begin
               w_in_ready[i] = w_in_ready[i] & bus.in_valid[j];
            end
         end
      end
   end

   always_ff @(posedge C0) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_mem[k] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_xfer   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_result_p0;
            r_wr_ptr        <= f_ptr_next(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_ptr_next(r_rd_ptr);
            r_xfer   <= r_xfer + XFER_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_data   = r_mem[r_rd_ptr];
   assign bus.xfer_count = r_xfer;

endmodule
